ibuf_fill_ctrl: RTL and testbench

- Sits directly upstream of the banked input buffer.
- Accepts one fill command (base row address, beat count), then consumes DDR read beats of DDR_BANDWIDTH bits over a valid/ready handshake.
- Turns each accepted beat into one registered, all-bank write: per-bank write request, replicated write address, beat data on bs_write_data.
- Counts beats, wraps the row address, and reports completion with a one-cycle done pulse.

---
 rtl/ibuf_fill_ctrl_if.sv | 32 +++
 rtl/ibuf_fill_ctrl.sv | 110 +++++++++++
 tb/tb_ibuf_fill_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_fill_ctrl_if.sv
// rtl/ibuf_fill_ctrl_if.sv - command, DDR beat and bank-write bundle for the input-buffer fill controller
interface ibuf_fill_ctrl_if #(
    parameter int DDR_BANDWIDTH    = 512,
    parameter int NUM_BANKS        = 64,
    parameter int WRITE_ADDR_WIDTH = 8,
    parameter int COUNT_WIDTH      = 16
);
    logic                                  cmd_valid;
    logic                                  cmd_ready;
    logic [WRITE_ADDR_WIDTH-1:0]           cmd_base_addr;
    logic [COUNT_WIDTH-1:0]                cmd_num_beats;
    logic                                  ddr_data_valid;
    logic                                  ddr_data_ready;
    logic [DDR_BANDWIDTH-1:0]              ddr_data;
    logic [NUM_BANKS-1:0]                  bs_write_req;
    logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr;
    logic [DDR_BANDWIDTH-1:0]              bs_write_data;
    logic                                  busy;
    logic                                  done;

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_beats, ddr_data_valid, ddr_data,
        output cmd_ready, ddr_data_ready, bs_write_req, bs_write_addr, bs_write_data,
               busy, done
    );

    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_beats, ddr_data_valid, ddr_data,
        input  cmd_ready, ddr_data_ready, bs_write_req, bs_write_addr, bs_write_data,
               busy, done
    );
endinterface

// File: rtl/ibuf_fill_ctrl.sv
// rtl/ibuf_fill_ctrl.sv - turns one fill command plus DDR beats into registered all-bank input-buffer writes
module ibuf_fill_ctrl #(
    parameter int DDR_BANDWIDTH    = 512,
    parameter int NUM_BANKS        = 64,
    parameter int DATA_WIDTH       = 8,
    parameter int WRITE_ADDR_WIDTH = 8,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic              clk,
    input  logic              reset,
    ibuf_fill_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [WRITE_ADDR_WIDTH-1:0] row_ptr;
    logic [WRITE_ADDR_WIDTH-1:0] addr_q;
    logic [COUNT_WIDTH-1:0]      remaining;
    logic                        req_q;
    logic [DDR_BANDWIDTH-1:0]    data_q;

    logic cmd_ready_c;
    logic ddr_ready_c;
    logic busy_c;
    logic done_c;
    logic cmd_accept;
    logic beat_accept;

    assign cmd_accept  = bus.cmd_valid & cmd_ready_c;
    assign beat_accept = bus.ddr_data_valid & ddr_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready_c = 1'b0;
        ddr_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = (bus.cmd_num_beats == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                ddr_ready_c = 1'b1;
                busy_c      = 1'b1;
                // remaining is never 0 here, so exiting at 1 keeps it from underflowing
                if (bus.ddr_data_valid && remaining == COUNT_WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One register stage between the beat handshake and the bank write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            row_ptr   <= '0;
            remaining <= '0;
        end else begin
            req_q <= beat_accept;
            if (cmd_accept) begin
                row_ptr   <= bus.cmd_base_addr;
                remaining <= bus.cmd_num_beats;
            end
            if (beat_accept) begin
                addr_q    <= row_ptr;
                data_q    <= bus.ddr_data;
                row_ptr   <= row_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.ddr_data_ready = ddr_ready_c;
    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.bs_write_req   = {NUM_BANKS{req_q}};

    for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
        assign bus.bs_write_addr[n*WRITE_ADDR_WIDTH +: WRITE_ADDR_WIDTH] = addr_q;
        assign bus.bs_write_data[n*DATA_WIDTH +: DATA_WIDTH] = data_q[n*DATA_WIDTH +: DATA_WIDTH];
    end
endmodule

// File: tb/tb_ibuf_fill_ctrl.sv
// tb/tb_ibuf_fill_ctrl.sv - directed self-checking bench for ibuf_fill_ctrl
module tb_ibuf_fill_ctrl;
    localparam int DDRW = 512;
    localparam int NB   = 64;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int CW   = 16;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ibuf_fill_ctrl_if #(
        .DDR_BANDWIDTH(DDRW), .NUM_BANKS(NB), .WRITE_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
    ) bus ();

    ibuf_fill_ctrl #(
        .DDR_BANDWIDTH(DDRW), .NUM_BANKS(NB), .DATA_WIDTH(DW),
        .WRITE_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DDRW-1:0] beat(input int k);
        logic [31:0] w;
        w = 32'hD00D_0000 | 32'(k);
        return {16{w}};
    endfunction

    function automatic logic [NB*AW-1:0] rows(input logic [AW-1:0] r);
        return {NB{r}};
    endfunction

    // Advance one edge and settle; outputs are observed and inputs changed 1ns after posedge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_num_beats = '0;
        bus.ddr_data_valid = 1'b0; bus.ddr_data = '0;
        tick; tick;
        n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL rst_req got=%h want=0", bus.bs_write_req); end
        n_vec++; if (bus.bs_write_addr !== '0) begin n_err++; $display("FAIL rst_addr got=%h want=0", bus.bs_write_addr); end
        n_vec++; if (bus.bs_write_data !== '0) begin n_err++; $display("FAIL rst_data got=%h want=0", bus.bs_write_data); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b want=0", bus.done); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got=%b want=1", bus.cmd_ready); end
        n_vec++; if (bus.ddr_data_ready !== 1'b0) begin n_err++; $display("FAIL rst_ddr_ready got=%b want=0", bus.ddr_data_ready); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [AW-1:0] r;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h10; bus.cmd_num_beats = 16'd4;
        tick;
        bus.cmd_valid = 1'b0;
        n_vec++; if (bus.ddr_data_ready !== 1'b1) begin n_err++; $display("FAIL basic_ddr_ready got=%b want=1", bus.ddr_data_ready); end
        n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL basic_cmd_ready_load got=%b want=0", bus.cmd_ready); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
        bus.ddr_data_valid = 1'b1; bus.ddr_data = beat(0);
        for (int i = 0; i < 4; i++) begin
            tick;
            bus.ddr_data = beat(i + 1);
            if (i == 3) bus.ddr_data_valid = 1'b0;
            r = 8'h10 + AW'(i);
            n_vec++; if (bus.bs_write_req !== {NB{1'b1}}) begin n_err++; $display("FAIL basic_req[%0d] got=%h want=all-ones", i, bus.bs_write_req); end
            n_vec++; if (bus.bs_write_addr !== rows(r)) begin n_err++; $display("FAIL basic_addr[%0d] got=%h want=%h", i, bus.bs_write_addr[AW-1:0], r); end
            n_vec++; if (bus.bs_write_data !== beat(i)) begin n_err++; $display("FAIL basic_data[%0d] got=%h want=%h", i, bus.bs_write_data[31:0], beat(i) & 32'hFFFF_FFFF); end
            n_vec++; if (bus.done !== (i == 3)) begin n_err++; $display("FAIL basic_done[%0d] got=%b want=%b", i, bus.done, (i == 3)); end
        end
        tick;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_cmd_ready_after got=%b want=1", bus.cmd_ready); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_after got=%b want=0", bus.done); end
        n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL basic_req_after got=%h want=0", bus.bs_write_req); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] r;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'hFE; bus.cmd_num_beats = 16'd4;
        tick;
        bus.cmd_valid = 1'b0;
        bus.ddr_data_valid = 1'b1; bus.ddr_data = beat(16);
        for (int i = 0; i < 4; i++) begin
            tick;
            bus.ddr_data = beat(17 + i);
            if (i == 3) bus.ddr_data_valid = 1'b0;
            r = 8'hFE + AW'(i);
            n_vec++; if (bus.bs_write_req !== {NB{1'b1}}) begin n_err++; $display("FAIL wrap_req[%0d] got=%h want=all-ones", i, bus.bs_write_req); end
            n_vec++; if (bus.bs_write_addr !== rows(r)) begin n_err++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, bus.bs_write_addr[AW-1:0], r); end
            n_vec++; if (bus.bs_write_data !== beat(16 + i)) begin n_err++; $display("FAIL wrap_data[%0d] got=%h", i, bus.bs_write_data[31:0]); end
        end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%b want=1", bus.done); end
        tick;
    endtask

    task automatic test_gapped;
        logic [5:0]    pat;
        logic [AW-1:0] r;
        int            nacc;
        pat  = 6'b101001;
        nacc = 0;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h40; bus.cmd_num_beats = 16'd3;
        tick;
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            bus.ddr_data_valid = pat[j];
            bus.ddr_data = beat(32 + j);
            tick;
            if (pat[j]) nacc++;
            r = 8'h40 + AW'(nacc - 1);
            n_vec++; if (bus.bs_write_req !== {NB{pat[j]}}) begin n_err++; $display("FAIL gap_req[%0d] got=%h want=%b", j, bus.bs_write_req[0], pat[j]); end
            n_vec++; if (bus.bs_write_addr !== rows(r)) begin n_err++; $display("FAIL gap_addr[%0d] got=%h want=%h", j, bus.bs_write_addr[AW-1:0], r); end
            n_vec++; if (bus.done !== (nacc == 3)) begin n_err++; $display("FAIL gap_done[%0d] got=%b want=%b", j, bus.done, (nacc == 3)); end
        end
        n_vec++; if (bus.bs_write_data !== beat(37)) begin n_err++; $display("FAIL gap_last_data got=%h want=%h", bus.bs_write_data[31:0], beat(37) & 32'hFFFF_FFFF); end
        bus.ddr_data_valid = 1'b0;
        tick;
    endtask

    task automatic test_zero;
        int pulses;
        pulses = 0;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h77; bus.cmd_num_beats = 16'd0;
        bus.ddr_data_valid = 1'b1; bus.ddr_data = beat(99);
        tick;
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (bus.done === 1'b1) pulses++;
            n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL zero_req[%0d] got=%h want=0", j, bus.bs_write_req); end
            n_vec++; if (bus.ddr_data_ready !== 1'b0) begin n_err++; $display("FAIL zero_ddr_ready[%0d] got=%b want=0", j, bus.ddr_data_ready); end
            tick;
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL zero_done_pulses got=%0d want=1", pulses); end
        n_vec++; if (bus.bs_write_data !== beat(37)) begin n_err++; $display("FAIL zero_data_held got=%h want=%h", bus.bs_write_data[31:0], beat(37) & 32'hFFFF_FFFF); end
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_cmd_ready got=%b want=1", bus.cmd_ready); end
        bus.ddr_data_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h30; bus.cmd_num_beats = 16'd8;
        tick;
        bus.cmd_valid = 1'b0;
        bus.ddr_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ddr_data = beat(48 + i);
            tick;
        end
        n_vec++; if (bus.bs_write_addr !== rows(8'h32)) begin n_err++; $display("FAIL mid_addr_before got=%h want=32", bus.bs_write_addr[AW-1:0]); end
        reset = 1'b1;
        bus.ddr_data = beat(51);
        tick;
        reset = 1'b0;
        bus.ddr_data_valid = 1'b0;
        n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL mid_req got=%h want=0", bus.bs_write_req); end
        n_vec++; if (bus.bs_write_addr !== '0) begin n_err++; $display("FAIL mid_addr got=%h want=0", bus.bs_write_addr[AW-1:0]); end
        n_vec++; if (bus.bs_write_data !== '0) begin n_err++; $display("FAIL mid_data got=%h want=0", bus.bs_write_data[31:0]); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_cmd_ready got=%b want=1", bus.cmd_ready); end
        for (int j = 0; j < 3; j++) begin
            if (bus.done === 1'b1) pulses++;
            tick;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL mid_done_pulses got=%0d want=0", pulses); end
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h20; bus.cmd_num_beats = 16'd1;
        tick;
        bus.cmd_valid = 1'b0;
        bus.ddr_data_valid = 1'b1; bus.ddr_data = beat(64);
        tick;
        bus.ddr_data_valid = 1'b0;
        n_vec++; if (bus.bs_write_req !== {NB{1'b1}}) begin n_err++; $display("FAIL mid_new_req got=%h want=all-ones", bus.bs_write_req); end
        n_vec++; if (bus.bs_write_addr !== rows(8'h20)) begin n_err++; $display("FAIL mid_new_addr got=%h want=20", bus.bs_write_addr[AW-1:0]); end
        n_vec++; if (bus.bs_write_data !== beat(64)) begin n_err++; $display("FAIL mid_new_data got=%h", bus.bs_write_data[31:0]); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL mid_new_done got=%b want=1", bus.done); end
        tick;
    endtask

    task automatic test_protocol;
        logic [AW-1:0] r;
        bus.ddr_data_valid = 1'b1; bus.ddr_data = beat(80);
        for (int j = 0; j < 3; j++) begin
            tick;
            n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL proto_idle_req[%0d] got=%h want=0", j, bus.bs_write_req); end
            n_vec++; if (bus.bs_write_data !== beat(64)) begin n_err++; $display("FAIL proto_idle_data[%0d] got=%h", j, bus.bs_write_data[31:0]); end
        end
        bus.ddr_data_valid = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = 8'h50; bus.cmd_num_beats = 16'd2;
        tick;
        bus.cmd_base_addr = 8'h77; bus.cmd_num_beats = 16'd5;
        bus.ddr_data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.ddr_data = beat(90 + i);
            tick;
            r = 8'h50 + AW'(i);
            n_vec++; if (bus.bs_write_addr !== rows(r)) begin n_err++; $display("FAIL proto_addr[%0d] got=%h want=%h", i, bus.bs_write_addr[AW-1:0], r); end
            n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL proto_cmd_ready[%0d] got=%b want=0", i, bus.cmd_ready); end
        end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL proto_done got=%b want=1", bus.done); end
        tick;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL proto_idle_ready got=%b want=1", bus.cmd_ready); end
        n_vec++; if (bus.bs_write_req !== '0) begin n_err++; $display("FAIL proto_done_req got=%h want=0", bus.bs_write_req); end
        tick;
        bus.cmd_valid = 1'b0;
        n_vec++; if (bus.ddr_data_ready !== 1'b1) begin n_err++; $display("FAIL proto_second_accept got=%b want=1", bus.ddr_data_ready); end
        for (int i = 0; i < 5; i++) begin
            bus.ddr_data = beat(100 + i);
            tick;
            r = 8'h77 + AW'(i);
            n_vec++; if (bus.bs_write_addr !== rows(r)) begin n_err++; $display("FAIL proto_second_addr[%0d] got=%h want=%h", i, bus.bs_write_addr[AW-1:0], r); end
        end
        bus.ddr_data_valid = 1'b0;
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL proto_second_done got=%b want=1", bus.done); end
        tick;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_basic;
        test_wrap;
        test_gapped;
        test_zero;
        test_reset_mid;
        test_protocol;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
